o_bram_drain: RTL
=================

Name: o_bram_drain

Overview:
Read-side counterpart of the matmul output path. The matmul system writes result words into O_BRAM; this block reads a contiguous region back out of O_BRAM and streams it to the host/DMA side over a valid/ready interface. It handles the 1-cycle BRAM read latency and full backpressure without dropping or duplicating words.

Parameters:
DATA_WIDTH, 32, O_BRAM word width and stream data width
ADDR_WIDTH, 32, O_BRAM address width (byte address, matches ext_addr_o_bram)
ADDR_STRIDE, 4, address increment per word (bytes)
LEN_WIDTH, 16, width of the word-count field

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle request pulse; sampled only in IDLE
base_addr  in  ADDR_WIDTH  byte address of first word; latched on accepted start
num_words  in  LEN_WIDTH  number of words to drain; latched on accepted start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle completion pulse
addr_o_bram  out  ADDR_WIDTH  O_BRAM read address
enable_o_bram  out  1  O_BRAM port enable (read issue)
w_enable_o_bram  out  4  byte write enables; constant 4'b0000
data_out_o_bram  in  DATA_WIDTH  O_BRAM read data, valid 1 cycle after enable
m_data  out  DATA_WIDTH  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready from sink
m_last  out  1  high with the final word of the region
DEBUG_state  out  2  current FSM state encoding

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE; busy, done, enable_o_bram, m_valid, m_last = 0; addr_o_bram=0; m_data=0; FIFO empty; issue/accept counters=0. Reset mid-transfer aborts immediately; in-flight BRAM data next cycle is discarded; no done pulse.
- FSM states: IDLE(0), READ(1), FLUSH(2), DONE(3).
- IDLE: start=1 -> latch base_addr, num_words; if num_words=0 -> DONE, else -> READ. start in any other state is ignored.
- READ: issue reads; addr_o_bram=base_addr + issued*ADDR_STRIDE (mod 2^ADDR_WIDTH, wraps silently). After the num_words-th issue -> FLUSH.
- FLUSH: no issues; wait until accepted count = num_words (last handshake) -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle; -> IDLE. A start during DONE is ignored.
- busy=1 in READ and FLUSH only.
- Read pipeline: enable_o_bram=1 in cycle t captures data_out_o_bram in cycle t+1 into a 2-entry FIFO (write at end of t+1). An inflight flag tracks the one outstanding read.
- Issue rule (credit): issue in READ iff (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready this cycle. Guarantees no FIFO overflow under any m_ready pattern.
- Stream: m_valid = FIFO non-empty; m_data = FIFO head; m_last = m_valid & (head is word index num_words-1). m_data/m_last held stable while m_valid=1 and m_ready=0.
- Latency: start accepted at cycle 0 -> first enable_o_bram at cycle 1 -> data written into FIFO end of cycle 2 -> m_valid=1 at cycle 3.
- Throughput: with m_ready held high, one word per cycle sustained; N words finish last handshake at cycle N+2; done at cycle N+3.
- Simultaneous FIFO push and pop: both take effect; count unchanged.
- Counters are LEN_WIDTH bits; num_words=2^LEN_WIDTH-1 is the largest region.

Test Plan:
- Basic: base_addr=0x100, num_words=4, O_BRAM[0x100..0x10C]=A0..A3, m_ready=1 -> addrs 0x100,0x104,0x108,0x10C on cycles 1-4; m_data A0..A3 on cycles 3-6; m_last only with A3; done pulse cycle 7; busy cycles 1-6.
- Backpressure: num_words=8, m_ready toggles 1,0,0,1,... -> all 8 words in order, none dropped or duplicated, data stable while stalled, enable_o_bram never raised when FIFO+inflight would exceed 2.
- Zero length: num_words=0 -> no enable_o_bram, no m_valid, done pulse cycle 1, busy never high.
- Start while busy: second start with base_addr=0x200 during READ -> ignored; only first region streamed; done single pulse.
- Reset mid-op: num_words=16, reset_n=0 after 5 handshakes -> next cycle all outputs at reset values, no done; new start then drains fresh region correctly.
- Wrap: base_addr=0xFFFFFFF8, num_words=4 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; w_enable_o_bram=0 throughout.

Source files
------------

// File: rtl/o_bram_drain.sv
// Streams a contiguous O_BRAM region out over valid/ready.
// Absorbs the 1-cycle BRAM read latency with a 2-entry skid FIFO and read credit.
module o_bram_drain #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ADDR_STRIDE = 4,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr_o_bram,
    output logic                  enable_o_bram,
    output logic [3:0]            w_enable_o_bram,
    input  logic [DATA_WIDTH-1:0] data_out_o_bram,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [1:0]            DEBUG_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_num_words;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_accepted;
    logic                  r_inflight_p1;

    logic [DATA_WIDTH-1:0] r_fifo_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_fifo_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_issue;
    logic [LEN_WIDTH-1:0]  w_last_idx;
    logic                  w_last_issue;
    logic                  w_last_pop;

    // Credit: FIFO words plus the outstanding read, net of this cycle's pop,
    // must leave room for the word a new read will deliver.
    always_comb begin
        w_pop        = (r_fifo_cnt != 2'd0) && m_ready;
        w_push       = r_inflight_p1;
        w_occ        = {1'b0, r_fifo_cnt} + {2'b00, r_inflight_p1} - {2'b00, w_pop};
        w_issue      = (r_state == S_READ) && (w_occ < 3'd2);
        w_last_idx   = r_num_words - LEN_WIDTH'(1);
        w_last_issue = w_issue && (r_issued == w_last_idx);
        w_last_pop   = w_pop && (r_accepted == w_last_idx);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_words == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (w_last_issue) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_last_pop) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy            = (r_state == S_READ) || (r_state == S_FLUSH);
        done            = (r_state == S_DONE);
        enable_o_bram   = w_issue;
        addr_o_bram     = r_addr;
        w_enable_o_bram = 4'b0000;
        m_valid         = (r_fifo_cnt != 2'd0);
        m_data          = r_fifo_mem[r_rd_ptr];
        m_last          = m_valid && (r_accepted == w_last_idx);
        DEBUG_state     = r_state;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue stage (p0): address generation and request bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr        <= '0;
            r_num_words   <= '0;
            r_issued      <= '0;
            r_inflight_p1 <= 1'b0;
        end else begin
            r_inflight_p1 <= w_issue;
            if ((r_state == S_IDLE) && start) begin
                r_addr      <= base_addr;
                r_num_words <= num_words;
                r_issued    <= '0;
            end else if (w_issue) begin
                r_addr   <= r_addr + ADDR_WIDTH'(ADDR_STRIDE);
                r_issued <= r_issued + LEN_WIDTH'(1);
            end
        end
    end

    // Capture stage (p1): BRAM data lands in the FIFO; sink drains from the head
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fifo_mem[0] <= '0;
            r_fifo_mem[1] <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_fifo_cnt    <= 2'd0;
            r_accepted    <= '0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= data_out_o_bram;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_fifo_cnt <= r_fifo_cnt + 2'(w_push) - 2'(w_pop);
            if ((r_state == S_IDLE) && start) begin
                r_accepted <= '0;
            end else if (w_pop) begin
                r_accepted <= r_accepted + LEN_WIDTH'(1);
            end
        end
    end

endmodule
